// File: rtl/rpn_stack_engine.sv
// Reverse-Polish arithmetic engine driving an external LIFO stack.
// Tokens in, push/pop out to the stack, results out over valid/ready.
module rpn_stack_engine #(
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic         tok_is_op,
    input  logic [B-1:0] tok_data,
    output logic         stk_push,
    output logic         stk_pop,
    output logic [B-1:0] stk_push_data,
    input  logic [B-1:0] stk_pop_data,
    input  logic         stk_empty,
    input  logic         stk_full,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [B-1:0] res_data,
    output logic         busy,
    output logic         err,
    output logic [1:0]   err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_V,
        S_POP_A,
        S_POP_B,
        S_PUSH_R,
        S_DUP_R,
        S_EMIT,
        S_ERR
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_DUP  = 3'd4;
    localparam logic [2:0] OP_DROP = 3'd5;
    localparam logic [2:0] OP_OUT  = 3'd6;

    localparam logic [1:0] E_UNDER = 2'b01;
    localparam logic [1:0] E_OVER  = 2'b10;
    localparam logic [1:0] E_ILL   = 2'b11;

    state_t       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [B-1:0] val_q, val_d;
    logic [B-1:0] a_q, a_d;
    logic [B-1:0] b_q, b_d;
    logic [B-1:0] pdata_q, pdata_d;
    logic [1:0]   ecode_q, ecode_d;
    logic         push;
    logic         pop;
    logic [B-1:0] push_val;
    logic [B-1:0] alu;

    // Operand order: b is the deeper word, a was on top.
    always_comb begin
        alu = '0;
        unique case (op_q)
            OP_ADD:  alu = b_q + a_q;
            OP_SUB:  alu = b_q - a_q;
            OP_MUL:  alu = b_q * a_q;
            OP_AND:  alu = b_q & a_q;
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        val_d    = val_q;
        a_d      = a_q;
        b_d      = b_q;
        ecode_d  = ecode_q;
        push     = 1'b0;
        pop      = 1'b0;
        push_val = val_q;
        unique case (state_q)
            S_IDLE: begin
                if (tok_valid) begin
                    op_d  = tok_data[2:0];
                    val_d = tok_data;
                    if (!tok_is_op) begin
                        state_d = S_PUSH_V;
                    end else begin
                        unique case (tok_data[2:0])
                            OP_DUP:  state_d = S_DUP_R;
                            3'd7: begin
                                state_d = S_ERR;
                                ecode_d = E_ILL;
                            end
                            default: state_d = S_POP_A;
                        endcase
                    end
                end
            end
            S_PUSH_V: begin
                if (stk_full) begin
                    state_d = S_ERR;
                    ecode_d = E_OVER;
                end else begin
                    push     = 1'b1;
                    push_val = val_q;
                    state_d  = S_IDLE;
                end
            end
            S_POP_A: begin
                if (stk_empty) begin
                    state_d = S_ERR;
                    ecode_d = E_UNDER;
                end else begin
                    a_d = stk_pop_data;
                    pop = 1'b1;
                    unique case (op_q)
                        OP_DROP: state_d = S_IDLE;
                        OP_OUT:  state_d = S_EMIT;
                        default: state_d = S_POP_B;
                    endcase
                end
            end
            S_POP_B: begin
                if (stk_empty) begin
                    state_d = S_ERR;
                    ecode_d = E_UNDER;
                end else begin
                    b_d     = stk_pop_data;
                    pop     = 1'b1;
                    state_d = S_PUSH_R;
                end
            end
            S_PUSH_R: begin
                push     = 1'b1;
                push_val = alu;
                state_d  = S_IDLE;
            end
            S_DUP_R: begin
                if (stk_empty) begin
                    state_d = S_ERR;
                    ecode_d = E_UNDER;
                end else if (stk_full) begin
                    state_d = S_ERR;
                    ecode_d = E_OVER;
                end else begin
                    val_d   = stk_pop_data;
                    state_d = S_PUSH_V;
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        pdata_d = push ? push_val : pdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            val_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pdata_q <= '0;
            ecode_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            val_q   <= val_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pdata_q <= pdata_d;
            ecode_q <= ecode_d;
        end
    end

    // Outputs are forced to their idle values while reset is held.
    always_comb begin
        tok_ready     = !reset && (state_q == S_IDLE);
        busy          = !reset && (state_q != S_IDLE);
        stk_push      = !reset && push;
        stk_pop       = !reset && pop;
        stk_push_data = reset ? '0 : (push ? push_val : pdata_q);
        res_valid     = !reset && (state_q == S_EMIT);
        res_data      = res_valid ? a_q : '0;
        err           = !reset && (state_q == S_ERR);
        err_code      = err ? ecode_q : 2'b00;
    end

endmodule

// File: doc/rpn_stack_engine.md
Name: rpn_stack_engine

Overview:
- Reverse-Polish arithmetic engine that masters the team's LIFO stack block through its push/pop interface.
- Consumes a token stream of operands and opcodes and drives push, push_data and pop into the stack.
- Reads pop_data, empty and full back from the stack and emits results over a valid/ready port.
- Sits between a token source (UART/decoder) and one stack instance; both share clk and reset.

Parameters:
- B, 8, data width of operands, stack words and results.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset. Clock is clk.
- tok_valid  in  1  token available.
- tok_ready  out  1  engine accepts token this cycle.
- tok_is_op  in  1  1 = tok_data is an opcode, 0 = operand.
- tok_data  in  B  operand value, or opcode in bits [2:0].
- stk_push  out  1  push request to stack.
- stk_pop  out  1  pop request to stack.
- stk_push_data  out  B  word to push.
- stk_pop_data  in  B  current top-of-stack; valid whenever stk_empty=0.
- stk_empty  in  1  stack empty.
- stk_full  in  1  stack full.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  B  result word.
- busy  out  1  state != IDLE.
- err  out  1  sticky error flag.
- err_code  out  2  00 none, 01 underflow, 10 overflow, 11 illegal opcode.

Behaviour:
- Stack contract:
  - Push/pop take effect at the clk edge.
  - stk_pop_data, stk_empty and stk_full reflect the new stack state the following cycle.
  - The engine never asserts stk_push and stk_pop in the same cycle.
  - The engine never pushes when stk_full=1 and never pops when stk_empty=1.
- Reset:
  - state=IDLE.
  - tok_ready=0 during reset, 1 from the first cycle after.
  - stk_push=0, stk_pop=0, stk_push_data=0.
  - res_valid=0, res_data=0, busy=0, err=0, err_code=00.
  - Reset mid-operation abandons the operation. The stack is cleared by its own reset (same reset net).
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 DUP, 5 DROP, 6 OUT, 7 illegal.
- Binary op result = b op a, where a = first popped (top) and b = second popped.
  - Arithmetic is modulo 2^B; MUL keeps the low B bits.
- Token handshake: tok_ready=1 only in IDLE. Accept when tok_valid&tok_ready; tok_is_op/tok_data are latched.
- FSM states: IDLE, PUSH_V, POP_A, POP_B, PUSH_R, DUP_R, EMIT, ERR.
  - IDLE, operand accepted -> PUSH_V.
  - IDLE, opcode 0-3 -> POP_A.
  - IDLE, opcode 4 -> DUP_R.
  - IDLE, opcode 5 or 6 -> POP_A.
  - IDLE, opcode 7 -> ERR (code 11).
  - PUSH_V: if stk_full -> ERR (10), no push. Else stk_push=1, stk_push_data=operand -> IDLE. Latency 2 cycles per operand.
  - POP_A: if stk_empty -> ERR (01). Else capture a=stk_pop_data, stk_pop=1.
    - Binary ops -> POP_B.
    - DROP -> IDLE.
    - OUT -> EMIT.
  - POP_B: if stk_empty -> ERR (01); a stays consumed (not restored). Else capture b, stk_pop=1 -> PUSH_R.
  - PUSH_R: stk_push=1, stk_push_data=result -> IDLE. Full cannot occur. Binary op = 4 cycles IDLE to IDLE.
  - DUP_R: if stk_empty -> ERR (01); elif stk_full -> ERR (10). Else capture top, no pop -> PUSH_V with the captured word (full rechecked there).
  - EMIT: res_valid=1, res_data=a, held stable until res_ready. On res_valid&res_ready -> IDLE; res_valid drops next cycle.
  - ERR: absorbing until reset. err=1 and err_code held; tok_ready=0; no stack traffic.
- stk_push/stk_pop are single-cycle pulses; stk_push_data holds its last value when not pushing.
- busy=1 in all states except IDLE.

Test Plan:
- Push 3, push 4, ADD, OUT (res_ready=1) -> stack sees 3 pushes and 3 pops; res_data=7 for one cycle; stack empty; err=0.
- Push 10, push 3, SUB, OUT -> res_data=7 (10-3). Push 3, push 10, SUB, OUT -> res_data=249 (B=8).
- Push 20, push 20, MUL, OUT -> res_data=144 (400 mod 256). Push 5, DUP, ADD, OUT -> 10.
- Push 1, ADD -> one pop, then ERR with err_code=01; tok_ready stays 0 while tok_valid is held high; reset -> err=0, tok_ready=1.
- Stack model depth 4: push 5 operands -> 4 stk_push pulses, 5th never pushed, err_code=10. Separately, opcode 7 -> err_code=11.
- OUT with res_ready=0 for 5 cycles -> res_valid and res_data stable, tok_ready=0. Then res_ready=1 -> single transfer. Reset asserted in POP_B -> all outputs at reset values next cycle.
